// File: rtl/exe_stage.sv
// exe_stage: execute stage that latches one decoded instruction, runs the one-hot ALU or an optional iterative divider, and issues the data-SRAM request.
// Ports: clk, rst (sync, active-low); ds_to_es_valid/ds_to_es_bus from decode; ms_allow_in from memory;
//        es_allow_in to decode; es_to_ms_valid/es_to_ms_bus to memory; es_fwd_bus for decode bypass;
//        data_sram_en/we/addr/wdata word-access SRAM request.
// Build option: define EXE_DIV_EN to compile in the 34-cycle restoring divider; otherwise div_op is ignored.
`ifndef DS_TO_ES_WD
`define DS_TO_ES_WD 151
`endif
`ifndef ES_TO_MS_WD
`define ES_TO_MS_WD 71
`endif
module exe_stage (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ds_to_es_valid,
    input  logic [`DS_TO_ES_WD-1:0] ds_to_es_bus,
    input  logic                    ms_allow_in,
    output logic                    es_allow_in,
    output logic                    es_to_ms_valid,
    output logic [`ES_TO_MS_WD-1:0] es_to_ms_bus,
    output logic [38:0]             es_fwd_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_we,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);
    logic                    es_valid;
    logic                    es_ready_go;
    logic [`DS_TO_ES_WD-1:0] es_bus;
    logic [11:0]             alu_op;
    logic [2:0]              div_op;
    logic [31:0]             src1, src2, st_data, pc;
    logic                    mem_we, rf_or_mem, rf_we;
    logic [4:0]              dest;
    logic [4:0]              sh;
    logic [31:0]             alu_result, result;

    assign {alu_op, div_op, src1, src2, st_data, mem_we, rf_or_mem, rf_we, dest, pc} = es_bus;
    assign sh = src2[4:0];

    // one-hot select: AND-OR of every candidate result
    assign alu_result = ({32{alu_op[0]}}  & (src1 + src2))
                      | ({32{alu_op[1]}}  & (src1 - src2))
                      | ({32{alu_op[2]}}  & {31'b0, $signed(src1) < $signed(src2)})
                      | ({32{alu_op[3]}}  & {31'b0, src1 < src2})
                      | ({32{alu_op[4]}}  & (src1 & src2))
                      | ({32{alu_op[5]}}  & ~(src1 | src2))
                      | ({32{alu_op[6]}}  & (src1 | src2))
                      | ({32{alu_op[7]}}  & (src1 ^ src2))
                      | ({32{alu_op[8]}}  & (src1 << sh))
                      | ({32{alu_op[9]}}  & (src1 >> sh))
                      | ({32{alu_op[10]}} & 32'($signed(src1) >>> sh))
                      | ({32{alu_op[11]}} & src2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            es_valid <= 1'b0;
            es_bus   <= '0;
        end else if (es_allow_in) begin
            es_valid <= ds_to_es_valid;
            if (ds_to_es_valid) es_bus <= ds_to_es_bus;
        end
    end

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs, div_q, div_r;
    logic        q_neg, r_neg, div_en, s1, s2;
    logic [32:0] trial, diff;

    assign div_en = div_op[2];
    assign s1     = div_op[1] & src1[31];
    assign s2     = div_op[1] & src2[31];
    // quo starts as the dividend and shifts its bits into the partial remainder
    assign trial  = {rem, quo[31]};
    assign diff   = trial - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (es_valid && div_en) state_nxt = BUSY;
            BUSY:    if (cnt == 5'd31) state_nxt = DONE;
            DONE:    if (ms_allow_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE) begin
            cnt   <= '0;
            quo   <= s1 ? -src1 : src1;
            dvs   <= s2 ? -src2 : src2;
            rem   <= '0;
            q_neg <= s1 ^ s2;
            r_neg <= s1;
        end else if (state == BUSY) begin
            cnt <= cnt + 5'd1;
            quo <= {quo[30:0], ~diff[32]};
            rem <= diff[32] ? trial[31:0] : diff[31:0];
        end
    end

    // a zero divisor bypasses the sign fixup so the dividend comes back untouched
    assign div_q       = (src2 == 32'd0) ? 32'hFFFF_FFFF : (q_neg ? -quo : quo);
    assign div_r       = (src2 == 32'd0) ? src1 : (r_neg ? -rem : rem);
    assign result      = div_en ? (div_op[0] ? div_r : div_q) : alu_result;
    assign es_ready_go = !(es_valid && div_en) || state == DONE;
`else
    logic unused_div;
    assign unused_div  = ^div_op;
    assign result      = alu_result;
    assign es_ready_go = 1'b1;
`endif

    assign es_allow_in     = !es_valid || (es_ready_go && ms_allow_in);
    assign es_to_ms_valid  = es_valid && es_ready_go;
    assign es_to_ms_bus    = {rf_or_mem, rf_we, dest, pc, result};
    assign es_fwd_bus      = {es_valid && rf_we, rf_or_mem, dest, result};
    assign data_sram_en    = es_to_ms_valid && ms_allow_in && (mem_we || rf_or_mem);
    assign data_sram_we    = {4{data_sram_en && mem_we}};
    assign data_sram_addr  = result;
    assign data_sram_wdata = st_data;
endmodule
